// File: rtl/evm_pkg.sv
// Shared types and helpers for the EVM polling-session controller.
package evm_pkg;

  localparam int N_CAND_DEF = 4;

  typedef enum logic [2:0] {
    CLOSED      = 3'd0,
    WAIT_BALLOT = 3'd1,
    ARMED       = 3'd2,
    COMMIT      = 3'd3,
    LOCKOUT     = 3'd4,
    RESULTS     = 3'd5
  } evm_state_t;

  // True when exactly one bit of v is set; callers zero-extend narrower vectors.
  function automatic logic onehot_valid(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/evm_session_if.sv
// Officer controls, button requests and controller status for one polling session.
interface evm_session_if
  import evm_pkg::*;
#(
  parameter int N_CAND  = N_CAND_DEF,
  parameter int TOTAL_W = 10
);
  localparam int SEL_W = (N_CAND > 1) ? $clog2(N_CAND) : 1;

  // vote_req carries one-cycle valid pulses and has no ready: a request is consumed
  // only when it lands in ARMED and is otherwise dropped. vote_grant is a one-cycle
  // commit strobe that the votelogger must accept unconditionally.
  logic               open_poll;
  logic               close_poll;
  logic               ballot_issue;
  logic [N_CAND-1:0]  vote_req;
  logic [N_CAND-1:0]  vote_grant;
  logic               ballot_ready;
  logic               busy;
  logic               reject_pulse;
  logic               timeout_pulse;
  logic               results_mode;
  logic [SEL_W-1:0]   disp_sel;
  logic [TOTAL_W-1:0] total_votes;
  evm_state_t         state;

  modport master (
    output open_poll, close_poll, ballot_issue, vote_req,
    input  vote_grant, ballot_ready, busy, reject_pulse, timeout_pulse,
    input  results_mode, disp_sel, total_votes, state
  );

  modport slave (
    input  open_poll, close_poll, ballot_issue, vote_req,
    output vote_grant, ballot_ready, busy, reject_pulse, timeout_pulse,
    output results_mode, disp_sel, total_votes, state
  );
endinterface

// File: rtl/evm_cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module evm_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);
  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);
endmodule

// File: rtl/evm_session_ctrl.sv
// Polling-session controller: one vote per issued ballot, post-vote lockout,
// and a results walk over the candidates once the poll closes.
module evm_session_ctrl
  import evm_pkg::*;
#(
  parameter int N_CAND         = N_CAND_DEF,
  parameter int LOCKOUT_CYCLES = 8,
  parameter int ARM_TIMEOUT    = 1024,
  parameter int DISPLAY_CYCLES = 16,
  parameter int TOTAL_W        = 10
) (
  input  logic          clock,
  input  logic          reset,
  evm_session_if.slave  bus
);
  localparam int SEL_W  = (N_CAND > 1) ? $clog2(N_CAND) : 1;
  localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int ARM_W  = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
  localparam int DISP_W = (DISPLAY_CYCLES > 1) ? $clog2(DISPLAY_CYCLES) : 1;

  evm_state_t         state;
  logic               close_pending;
  logic [N_CAND-1:0]  vote_grant_q;
  logic               ballot_ready_q;
  logic               busy_q;
  logic               reject_q;
  logic               timeout_q;
  logic               results_q;
  logic [SEL_W-1:0]   disp_sel_q;
  logic [TOTAL_W-1:0] total_q;

  logic req_none;
  logic req_one;
  logic lock_done;
  logic arm_done;
  logic disp_done;
  logic lock_load;
  logic arm_load;
  logic arm_en;
  logic disp_load;

  assign req_none = (bus.vote_req == '0);
  assign req_one  = onehot_valid(32'(bus.vote_req));

  // Timers are held preloaded outside their own state, so entering a state starts a full period.
  always_comb begin
    lock_load = (state != LOCKOUT);
    arm_load  = (state != ARMED);
    arm_en    = (state == ARMED) && req_none;
    disp_load = (state != RESULTS) || disp_done;
  end

  evm_cycle_timer #(.W(LOCK_W)) u_lock_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (lock_load),
    .load_val (LOCK_W'(LOCKOUT_CYCLES - 1)),
    .en       (state == LOCKOUT),
    .done     (lock_done)
  );

  evm_cycle_timer #(.W(ARM_W)) u_arm_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (arm_load),
    .load_val (ARM_W'(ARM_TIMEOUT - 1)),
    .en       (arm_en),
    .done     (arm_done)
  );

  evm_cycle_timer #(.W(DISP_W)) u_disp_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (disp_load),
    .load_val (DISP_W'(DISPLAY_CYCLES - 1)),
    .en       (state == RESULTS),
    .done     (disp_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= CLOSED;
      close_pending  <= 1'b0;
      vote_grant_q   <= '0;
      ballot_ready_q <= 1'b0;
      busy_q         <= 1'b0;
      reject_q       <= 1'b0;
      timeout_q      <= 1'b0;
      results_q      <= 1'b0;
      disp_sel_q     <= '0;
      total_q        <= '0;
    end else begin
      vote_grant_q <= '0;
      reject_q     <= 1'b0;
      timeout_q    <= 1'b0;
      case (state)
        CLOSED: begin
          if (bus.open_poll) begin
            state   <= WAIT_BALLOT;
            total_q <= '0;
          end
        end
        WAIT_BALLOT: begin
          if (bus.close_poll || close_pending) begin
            state         <= RESULTS;
            results_q     <= 1'b1;
            disp_sel_q    <= '0;
            close_pending <= 1'b0;
          end else if (bus.ballot_issue) begin
            state          <= ARMED;
            ballot_ready_q <= 1'b1;
          end
        end
        ARMED: begin
          if (bus.close_poll) close_pending <= 1'b1;
          // A valid press in the expiry cycle is still honoured.
          if (req_one) begin
            state          <= COMMIT;
            vote_grant_q   <= bus.vote_req;
            ballot_ready_q <= 1'b0;
            busy_q         <= 1'b1;
          end else if (!req_none) begin
            reject_q <= 1'b1;
          end else if (arm_done) begin
            state          <= WAIT_BALLOT;
            timeout_q      <= 1'b1;
            ballot_ready_q <= 1'b0;
          end
        end
        COMMIT: begin
          if (bus.close_poll) close_pending <= 1'b1;
          if (total_q != '1) total_q <= total_q + TOTAL_W'(1);
          state <= LOCKOUT;
        end
        LOCKOUT: begin
          if (bus.close_poll) close_pending <= 1'b1;
          if (lock_done) begin
            state  <= WAIT_BALLOT;
            busy_q <= 1'b0;
          end
        end
        RESULTS: begin
          if (disp_done) begin
            disp_sel_q <= (disp_sel_q == SEL_W'(N_CAND - 1)) ? '0 : disp_sel_q + SEL_W'(1);
          end
        end
        default: state <= CLOSED;
      endcase
    end
  end

  assign bus.vote_grant    = vote_grant_q;
  assign bus.ballot_ready  = ballot_ready_q;
  assign bus.busy          = busy_q;
  assign bus.reject_pulse  = reject_q;
  assign bus.timeout_pulse = timeout_q;
  assign bus.results_mode  = results_q;
  assign bus.disp_sel      = disp_sel_q;
  assign bus.total_votes   = total_q;
  assign bus.state         = state;
endmodule

// File: tb/tb_evm_session_ctrl.sv
// Bench for evm_session_ctrl: a default instance plus a TOTAL_W=2 instance for saturation.
module tb_evm_session_ctrl;
  import evm_pkg::*;

  logic clock;
  logic reset;
  int   tests_run;
  int   tests_failed;
  logic [3:0] exp_q[$];
  logic [3:0] exp_q2[$];

  evm_session_if #(.N_CAND(4), .TOTAL_W(10)) bus_a ();
  evm_session_if #(.N_CAND(4), .TOTAL_W(2))  bus_b ();

  evm_session_ctrl #(.N_CAND(4), .LOCKOUT_CYCLES(8), .ARM_TIMEOUT(1024),
                     .DISPLAY_CYCLES(16), .TOTAL_W(10)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  evm_session_ctrl #(.N_CAND(4), .LOCKOUT_CYCLES(8), .ARM_TIMEOUT(1024),
                     .DISPLAY_CYCLES(16), .TOTAL_W(2)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one cycle, sample after the edge, and score any grant seen on either DUT.
  task automatic tick();
    logic [3:0] exp;
    @(posedge clock);
    #1;
    if (bus_a.vote_grant !== 4'b0) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL grant_a: got %b, expected no grant", bus_a.vote_grant);
      end else begin
        exp = exp_q.pop_front();
        if (bus_a.vote_grant !== exp) begin
          tests_failed++;
          $display("FAIL grant_a: got %b, expected %b", bus_a.vote_grant, exp);
        end
      end
    end
    if (bus_b.vote_grant !== 4'b0) begin
      tests_run++;
      if (exp_q2.size() == 0) begin
        tests_failed++;
        $display("FAIL grant_b: got %b, expected no grant", bus_b.vote_grant);
      end else begin
        exp = exp_q2.pop_front();
        if (bus_b.vote_grant !== exp) begin
          tests_failed++;
          $display("FAIL grant_b: got %b, expected %b", bus_b.vote_grant, exp);
        end
      end
    end
  endtask

  task automatic idle_inputs();
    bus_a.open_poll = 0; bus_a.close_poll = 0; bus_a.ballot_issue = 0; bus_a.vote_req = '0;
    bus_b.open_poll = 0; bus_b.close_poll = 0; bus_b.ballot_issue = 0; bus_b.vote_req = '0;
  endtask

  // Waits (bounded) for DUT A to return to WAIT_BALLOT after a commit.
  task automatic wait_ballot_a();
    int n = 0;
    while (bus_a.state !== WAIT_BALLOT && n < 40) begin
      n++;
      tick();
    end
    tests_run++;
    if (bus_a.state !== WAIT_BALLOT) begin
      tests_failed++;
      $display("FAIL wait_ballot_a: state %0d, expected %0d", bus_a.state, WAIT_BALLOT);
    end
  endtask

  task automatic issue_ballot_a();
    bus_a.ballot_issue = 1;
    tick();
    bus_a.ballot_issue = 0;
  endtask

  task automatic check_all_zero(input string name);
    tests_run++;
    if ({bus_a.vote_grant, bus_a.ballot_ready, bus_a.busy, bus_a.reject_pulse,
         bus_a.timeout_pulse, bus_a.results_mode, bus_a.disp_sel, bus_a.total_votes} !== '0
        || bus_a.state !== CLOSED) begin
      tests_failed++;
      $display("FAIL %s: grant=%b rdy=%b busy=%b rej=%b to=%b res=%b sel=%0d tot=%0d state=%0d, expected all 0 / CLOSED",
               name, bus_a.vote_grant, bus_a.ballot_ready, bus_a.busy, bus_a.reject_pulse,
               bus_a.timeout_pulse, bus_a.results_mode, bus_a.disp_sel, bus_a.total_votes, bus_a.state);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    check_all_zero("reset_state");
    reset = 0;
    bus_a.ballot_issue = 1;
    bus_a.vote_req = 4'b0001;
    tick();
    idle_inputs();
    check_all_zero("closed_ignores_inputs");
  endtask

  task automatic test_single_vote();
    int n;
    bus_a.open_poll = 1;
    tick();
    bus_a.open_poll = 0;
    tests_run++;
    if (bus_a.state !== WAIT_BALLOT || bus_a.total_votes !== 10'd0) begin
      tests_failed++;
      $display("FAIL open_poll: state %0d total %0d, expected %0d / 0", bus_a.state, bus_a.total_votes, WAIT_BALLOT);
    end
    issue_ballot_a();
    tests_run++;
    if (bus_a.ballot_ready !== 1'b1 || bus_a.state !== ARMED) begin
      tests_failed++;
      $display("FAIL armed: ready %b state %0d, expected 1 / %0d", bus_a.ballot_ready, bus_a.state, ARMED);
    end
    bus_a.vote_req = 4'b0010;
    exp_q.push_back(4'b0010);
    tick();
    bus_a.vote_req = '0;
    tests_run++;
    if (exp_q.size() != 0 || bus_a.ballot_ready !== 1'b0 || bus_a.busy !== 1'b1 || bus_a.total_votes !== 10'd0) begin
      tests_failed++;
      $display("FAIL commit_cycle: pending %0d ready %b busy %b total %0d, expected 0 / 0 / 1 / 0",
               exp_q.size(), bus_a.ballot_ready, bus_a.busy, bus_a.total_votes);
    end
    n = 0;
    while (bus_a.busy === 1'b1 && n < 30) begin
      n++;
      tick();
      if (n == 1) begin
        tests_run++;
        if (bus_a.total_votes !== 10'd1) begin
          tests_failed++;
          $display("FAIL total_after_commit: got %0d, expected 1", bus_a.total_votes);
        end
      end
    end
    tests_run++;
    if (n != 9 || bus_a.state !== WAIT_BALLOT) begin
      tests_failed++;
      $display("FAIL busy_length: got %0d cycles state %0d, expected 9 / %0d", n, bus_a.state, WAIT_BALLOT);
    end
  endtask

  task automatic test_reject();
    issue_ballot_a();
    bus_a.vote_req = 4'b0101;
    tick();
    bus_a.vote_req = '0;
    tests_run++;
    if (bus_a.reject_pulse !== 1'b1 || bus_a.ballot_ready !== 1'b1 || bus_a.state !== ARMED) begin
      tests_failed++;
      $display("FAIL multi_press: rej %b ready %b state %0d, expected 1 / 1 / %0d",
               bus_a.reject_pulse, bus_a.ballot_ready, bus_a.state, ARMED);
    end
    tick();
    tests_run++;
    if (bus_a.reject_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL reject_one_cycle: got %b, expected 0", bus_a.reject_pulse);
    end
    bus_a.vote_req = 4'b1000;
    exp_q.push_back(4'b1000);
    tick();
    bus_a.vote_req = 4'b0100;
    bus_a.ballot_issue = 1;
    tick();
    tick();
    tick();
    idle_inputs();
    wait_ballot_a();
    bus_a.vote_req = 4'b0001;
    tick();
    bus_a.vote_req = '0;
    tests_run++;
    if (bus_a.reject_pulse !== 1'b0 || bus_a.state !== WAIT_BALLOT || bus_a.total_votes !== 10'd2 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL ignored_reqs: rej %b state %0d total %0d pending %0d, expected 0 / %0d / 2 / 0",
               bus_a.reject_pulse, bus_a.state, bus_a.total_votes, exp_q.size(), WAIT_BALLOT);
    end
  endtask

  task automatic test_timeout();
    issue_ballot_a();
    repeat (1023) tick();
    tests_run++;
    if (bus_a.state !== ARMED || bus_a.timeout_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL before_expiry: state %0d to %b, expected %0d / 0", bus_a.state, bus_a.timeout_pulse, ARMED);
    end
    tick();
    tests_run++;
    if (bus_a.timeout_pulse !== 1'b1 || bus_a.state !== WAIT_BALLOT || bus_a.ballot_ready !== 1'b0 || bus_a.total_votes !== 10'd2) begin
      tests_failed++;
      $display("FAIL expiry: to %b state %0d ready %b total %0d, expected 1 / %0d / 0 / 2",
               bus_a.timeout_pulse, bus_a.state, bus_a.ballot_ready, bus_a.total_votes, WAIT_BALLOT);
    end
    tick();
    tests_run++;
    if (bus_a.timeout_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_one_cycle: got %b, expected 0", bus_a.timeout_pulse);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] v;
    for (int k = 0; k < 3; k++) begin
      issue_ballot_a();
      repeat ($urandom_range(0, 5)) tick();
      v = 4'b0001 << $urandom_range(0, 3);
      bus_a.vote_req = v;
      exp_q.push_back(v);
      tick();
      bus_a.vote_req = '0;
      wait_ballot_a();
    end
    tests_run++;
    if (bus_a.total_votes !== 10'd5) begin
      tests_failed++;
      $display("FAIL back_to_back_total: got %0d, expected 5", bus_a.total_votes);
    end
  endtask

  task automatic test_close_results();
    int n;
    logic [1:0] exp_sel;
    issue_ballot_a();
    bus_a.close_poll = 1;
    tick();
    bus_a.close_poll = 0;
    tests_run++;
    if (bus_a.state !== ARMED || bus_a.ballot_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL close_while_armed: state %0d ready %b, expected %0d / 1", bus_a.state, bus_a.ballot_ready, ARMED);
    end
    bus_a.vote_req = 4'b0001;
    exp_q.push_back(4'b0001);
    tick();
    bus_a.vote_req = '0;
    n = 0;
    while (bus_a.state !== RESULTS && n < 40) begin
      n++;
      tick();
    end
    tests_run++;
    if (bus_a.results_mode !== 1'b1 || bus_a.total_votes !== 10'd6 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL enter_results: res %b total %0d pending %0d, expected 1 / 6 / 0",
               bus_a.results_mode, bus_a.total_votes, exp_q.size());
    end
    bus_a.open_poll = 1;
    bus_a.ballot_issue = 1;
    bus_a.close_poll = 1;
    for (int i = 0; i < 80; i++) begin
      exp_sel = 2'((i / 16) % 4);
      tests_run++;
      if (bus_a.disp_sel !== exp_sel) begin
        tests_failed++;
        $display("FAIL disp_sel[%0d]: got %0d, expected %0d", i, bus_a.disp_sel, exp_sel);
      end
      bus_a.vote_req = 4'($urandom_range(0, 15));
      tick();
    end
    idle_inputs();
    tests_run++;
    if (bus_a.state !== RESULTS || bus_a.results_mode !== 1'b1 || bus_a.total_votes !== 10'd6) begin
      tests_failed++;
      $display("FAIL results_terminal: state %0d res %b total %0d, expected %0d / 1 / 6",
               bus_a.state, bus_a.results_mode, bus_a.total_votes, RESULTS);
    end
  endtask

  task automatic test_reset_mid_vote();
    reset = 1;
    tick();
    reset = 0;
    bus_a.open_poll = 1;
    tick();
    bus_a.open_poll = 0;
    issue_ballot_a();
    bus_a.vote_req = 4'b0100;
    reset = 1;
    tick();
    reset = 0;
    bus_a.vote_req = '0;
    check_all_zero("reset_mid_vote");
    tick();
    check_all_zero("after_reset_mid_vote");
  endtask

  task automatic test_saturation();
    logic [3:0] v;
    int n;
    reset = 1;
    tick();
    reset = 0;
    bus_b.open_poll = 1;
    tick();
    bus_b.open_poll = 0;
    for (int k = 1; k <= 5; k++) begin
      bus_b.ballot_issue = 1;
      tick();
      bus_b.ballot_issue = 0;
      v = 4'b0001 << $urandom_range(0, 3);
      bus_b.vote_req = v;
      exp_q2.push_back(v);
      tick();
      bus_b.vote_req = '0;
      n = 0;
      while (bus_b.state !== WAIT_BALLOT && n < 40) begin
        n++;
        tick();
      end
      tests_run++;
      if (bus_b.total_votes !== 2'((k > 3) ? 3 : k) || bus_b.state !== WAIT_BALLOT) begin
        tests_failed++;
        $display("FAIL saturation[%0d]: total %0d state %0d, expected %0d / %0d",
                 k, bus_b.total_votes, bus_b.state, (k > 3) ? 3 : k, WAIT_BALLOT);
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1;
    idle_inputs();
    test_reset();
    test_single_vote();
    test_reject();
    test_timeout();
    test_back_to_back();
    test_close_results();
    test_reset_mid_vote();
    test_saturation();
    tests_run++;
    if (exp_q.size() != 0 || exp_q2.size() != 0) begin
      tests_failed++;
      $display("FAIL missing_grants: %0d / %0d still queued, expected 0 / 0", exp_q.size(), exp_q2.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/evm_session_ctrl.md
Name: evm_session_ctrl

Overview:
- Polling-session controller for the EVM. It sits between the four button_control instances and the votelogger.
- Gates candidate vote requests so that exactly one vote is accepted per ballot issued by the polling officer, and rejects ambiguous multi-button presses.
- Enforces a post-vote lockout period.
- After the poll closes, drives results mode and steps the display select through the candidates.

Parameters:
- N_CAND, 4, number of candidates (width of the request and grant vectors).
- LOCKOUT_CYCLES, 8, cycles spent in lockout after each committed vote.
- ARM_TIMEOUT, 1024, cycles an issued ballot stays armed before it is voided.
- DISPLAY_CYCLES, 16, cycles each candidate is shown in results mode.
- TOTAL_W, 10, width of the total-votes counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- open_poll  in  1  officer opens the poll (level-sampled).
- close_poll  in  1  officer closes the poll.
- ballot_issue  in  1  officer issues one ballot.
- vote_req  in  N_CAND  per-candidate valid-vote pulses from button_control.
- vote_grant  out  N_CAND  one-hot, one-cycle commit strobe to the votelogger.
- ballot_ready  out  1  high while a ballot is armed.
- busy  out  1  high during commit and lockout.
- reject_pulse  out  1  one-cycle pulse on a multi-button press.
- timeout_pulse  out  1  one-cycle pulse when an armed ballot expires.
- results_mode  out  1  high in RESULTS; drives the EVM mode signal.
- disp_sel  out  $clog2(N_CAND)  index of the candidate currently displayed.
- total_votes  out  TOTAL_W  number of committed votes this session.

Behaviour:
- Clocking and reset:
  - Single clock. Reset is synchronous and active-high, and every flop uses it.
  - Reset forces state CLOSED, all outputs 0, all counters 0, and clears close_pending.
  - Reset mid-vote aborts the vote; no grant is emitted.
- All outputs are registered.
- States and transitions:
  - CLOSED:
    - open_poll → WAIT_BALLOT; total_votes is cleared on this transition.
    - All other inputs are ignored.
  - WAIT_BALLOT:
    - close_poll or close_pending → RESULTS; close takes priority over ballot_issue.
    - Otherwise ballot_issue → ARMED and the arm timer is cleared.
    - vote_req is silently ignored: no grant, no reject.
  - ARMED:
    - ballot_ready is 1.
    - vote_req sampled with exactly one bit set → COMMIT, and the index is latched.
    - vote_req with two or more bits set → reject_pulse=1 for one cycle; stay ARMED; the arm timer is not reset.
    - vote_req == 0 → the arm timer increments.
    - Arm timer reaching ARM_TIMEOUT-1 with no valid request → timeout_pulse=1 and → WAIT_BALLOT.
    - A single-bit request in the expiry cycle wins over the timeout.
    - close_poll sets close_pending and does not leave ARMED.
    - ballot_issue is ignored.
  - COMMIT (one cycle):
    - vote_grant = one-hot of the latched index; busy=1.
    - total_votes increments, saturating at 2^TOTAL_W-1.
    - → LOCKOUT.
  - LOCKOUT:
    - busy=1 for exactly LOCKOUT_CYCLES cycles; vote_req and ballot_issue are ignored.
    - Then → WAIT_BALLOT.
    - close_poll sets close_pending.
  - RESULTS:
    - results_mode=1.
    - disp_sel starts at 0 and advances every DISPLAY_CYCLES cycles, wrapping from N_CAND-1 to 0.
    - Terminal state: only reset leaves it. open_poll, close_poll, ballot_issue and vote_req are ignored.
- Latency:
  - vote_req sampled in ARMED at edge t.
  - vote_grant is high in cycle t+1.
  - total_votes shows the new value from t+2.
  - ballot_ready falls in the cycle grant rises.
- Invariants:
  - At most one vote_grant per ballot_issue.
  - vote_grant is never asserted outside COMMIT.
  - vote_grant is never multi-hot.

Decomposition:
- Shared package evm_pkg holds:
  - the state enum (CLOSED, WAIT_BALLOT, ARMED, COMMIT, LOCKOUT, RESULTS);
  - the N_CAND default;
  - the function onehot_valid(), which returns true when exactly one bit is set.
- One sub-module, evm_cycle_timer: a loadable down-counter with a done flag. It is instantiated for the lockout, arm-timeout and display-period counts.

Test Plan:
- Reset then open_poll, ballot_issue, vote_req=0010 → vote_grant=0010 one cycle later for exactly one cycle; busy high for 9 cycles; total_votes=1.
- ARMED with vote_req=0101 → reject_pulse=1, no grant, ballot_ready stays 1. A following vote_req=1000 → grant=1000.
- ballot_issue with no press for 1024 cycles → timeout_pulse=1, state WAIT_BALLOT, total_votes unchanged. vote_req pulses in WAIT_BALLOT and LOCKOUT → no grant.
- close_poll while ARMED, then vote_req=0001 → grant=0001, lockout completes, then results_mode=1. disp_sel sequence is 0,1,2,3,0, each held for 16 cycles.
- Reset asserted in the same cycle as a single-bit vote_req in ARMED → no grant; all outputs 0; state CLOSED.
- TOTAL_W=2: five committed votes → total_votes saturates at 3.
